// File: rtl/drp_pkg.sv
// Shared DRP definitions for drp_clk_div: bus widths, register map,
// CTRL bit positions and the responder FSM encoding.
package drp_pkg;

    localparam int DRP_AW = 11;
    localparam int DRP_DW = 16;

    localparam logic [DRP_AW-1:0] REG_CTRL       = 11'h000;
    localparam logic [DRP_AW-1:0] REG_STATUS     = 11'h001;
    localparam logic [DRP_AW-1:0] REG_DIV_BASE   = 11'h008;
    localparam logic [DRP_AW-1:0] REG_PHASE_BASE = 11'h009;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_SOFT_RST = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } drp_state_e;

    // DIV/PHASE registers are interleaved, two addresses per channel
    function automatic logic [DRP_AW-1:0] div_addr(input int i);
        return REG_DIV_BASE + DRP_AW'(2 * i);
    endfunction

    function automatic logic [DRP_AW-1:0] phase_addr(input int i);
        return REG_PHASE_BASE + DRP_AW'(2 * i);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One clock-enable divider channel. Phase offset support is compiled in
// with DRP_CLK_DIV_PHASE_EN; otherwise restarts always load zero.
module clk_div_chan
    import drp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DRP_DW-1:0] div,
    input  logic [DRP_DW-1:0] phase,
    input  logic              restart,
    input  logic              run,
    output logic              pulse
);

    logic [DRP_DW-1:0] cnt;
    logic [DRP_DW-1:0] start;
    logic              hit;
    logic              pulse_q;

`ifdef DRP_CLK_DIV_PHASE_EN
    assign start = (div <= 16'd1) ? '0 : (phase % div);
`else
    logic unused_phase;
    assign unused_phase = ^phase;
    assign start        = '0;
`endif

    // >= guards against a count left above a freshly shrunk divisor
    assign hit = (div <= 16'd1) || (cnt >= div - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= run & hit;
            if (restart)
                cnt <= start;
            else if (run)
                cnt <= hit ? '0 : cnt + 16'd1;
        end
    end

    // Gate with the live run so a disable or lock drop silences the pulse at once
    assign pulse = pulse_q & run;

endmodule

// File: rtl/drp_clk_div.sv
// DRP responder with a small register file driving NUM_DIV clock-enable
// dividers and a lock indicator. Optional feature macro: DRP_CLK_DIV_PHASE_EN.
module drp_clk_div
    import drp_pkg::*;
#(
    parameter int NUM_DIV     = 2,
    parameter int LATENCY     = 2,
    parameter int LOCK_CYCLES = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [DRP_AW-1:0]  daddr,
    input  logic               den,
    input  logic               dwe,
    input  logic [DRP_DW-1:0]  din,
    output logic [DRP_DW-1:0]  dout,
    output logic               drdy,
    output logic [NUM_DIV-1:0] o_clk_en,
    output logic               o_locked
);

    localparam int LW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int BUSY_LAST = (LATENCY > 1) ? LATENCY - 2 : 0;
    localparam int KW        = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1;

    drp_state_e                     state, state_nxt;
    logic [LW-1:0]                  lat_cnt;
    logic                           enable_q;
    logic [NUM_DIV-1:0][DRP_DW-1:0] div_q;
    logic [NUM_DIV-1:0][DRP_DW-1:0] phase_q;
    logic [NUM_DIV-1:0]             div_sel, phase_sel, restart_q;
    logic [KW-1:0]                  lock_cnt;
    logic [DRP_DW-1:0]              rdata, rdata_q;
    logic                           accept, wr, ctrl_wr, soft_rst, en_rise, lock_clr;

    assign accept   = den && (state == ST_IDLE);
    assign wr       = accept && dwe;
    assign ctrl_wr  = wr && (daddr == REG_CTRL);
    assign soft_rst = ctrl_wr && din[CTRL_SOFT_RST];
    assign en_rise  = ctrl_wr && din[CTRL_ENABLE] && !enable_q;
    assign lock_clr = soft_rst || en_rise || (wr && |(div_sel | phase_sel));

    always_comb begin
        div_sel   = '0;
        phase_sel = '0;
        rdata     = '0;
        if (daddr == REG_CTRL)
            rdata[CTRL_ENABLE] = enable_q;
        if (daddr == REG_STATUS)
            rdata[0] = o_locked;
        for (int i = 0; i < NUM_DIV; i++) begin
            if (daddr == div_addr(i)) begin
                div_sel[i] = 1'b1;
                rdata      = div_q[i];
            end
`ifdef DRP_CLK_DIV_PHASE_EN
            if (daddr == phase_addr(i)) begin
                phase_sel[i] = 1'b1;
                rdata        = phase_q[i];
            end
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= (state == ST_BUSY) ? lat_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (den) state_nxt = (LATENCY == 1) ? ST_RESP : ST_BUSY;
            ST_BUSY: if (lat_cnt == LW'(BUSY_LAST)) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign drdy = (state == ST_RESP);
    assign dout = drdy ? rdata_q : '0;

    // restart_q lags the write by one cycle so channels reload from the new values
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            enable_q  <= 1'b0;
            rdata_q   <= '0;
            restart_q <= '0;
            for (int i = 0; i < NUM_DIV; i++)
                div_q[i] <= 16'd1;
        end else begin
            restart_q <= {NUM_DIV{soft_rst}} | (wr ? (div_sel | phase_sel) : '0);
            if (accept)
                rdata_q <= dwe ? '0 : rdata;
            if (ctrl_wr)
                enable_q <= din[CTRL_ENABLE];
            for (int i = 0; i < NUM_DIV; i++)
                if (wr && div_sel[i])
                    div_q[i] <= din;
        end
    end

`ifdef DRP_CLK_DIV_PHASE_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            phase_q <= '0;
        end else begin
            for (int i = 0; i < NUM_DIV; i++)
                if (wr && phase_sel[i])
                    phase_q[i] <= din;
        end
    end
`else
    assign phase_q = '0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            lock_cnt <= '0;
        else if (!enable_q || lock_clr)
            lock_cnt <= '0;
        else if (lock_cnt != KW'(LOCK_CYCLES))
            lock_cnt <= lock_cnt + 1'b1;
    end

    assign o_locked = enable_q && (lock_cnt == KW'(LOCK_CYCLES));

    for (genvar g = 0; g < NUM_DIV; g++) begin : g_chan
        clk_div_chan u_chan (
            .clk     (i_clk),
            .rst     (i_reset),
            .div     (div_q[g]),
            .phase   (phase_q[g]),
            .restart (restart_q[g] | ~enable_q),
            .run     (o_locked),
            .pulse   (o_clk_en[g])
        );
    end

endmodule

// File: tb/tb_drp_clk_div.sv
// Directed bench for drp_clk_div: register-map vectors plus lock, divide,
// busy-drop, phase and reset-in-flight sequences.
module tb_drp_clk_div;

    localparam int NUM_DIV     = 2;
    localparam int LATENCY     = 2;
    localparam int LOCK_CYCLES = 16;

    logic               i_clk = 1'b0;
    logic               i_reset = 1'b1;
    logic [10:0]        daddr = '0;
    logic               den = 1'b0;
    logic               dwe = 1'b0;
    logic [15:0]        din = '0;
    logic [15:0]        dout;
    logic               drdy;
    logic [NUM_DIV-1:0] o_clk_en;
    logic               o_locked;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    drp_clk_div #(.NUM_DIV(NUM_DIV), .LATENCY(LATENCY), .LOCK_CYCLES(LOCK_CYCLES)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .daddr(daddr), .den(den), .dwe(dwe),
        .din(din), .dout(dout), .drdy(drdy), .o_clk_en(o_clk_en), .o_locked(o_locked)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [10:0] addr;
        logic        we;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic xfer(input logic [10:0] a, input logic we, input logic [15:0] d,
                        output logic [15:0] rd, output int lat, output int cap, output logic lk1);
        @(negedge i_clk);
        daddr = a; dwe = we; din = d; den = 1'b1;
        @(posedge i_clk);
        #1;
        cap = cyc; den = 1'b0; dwe = 1'b0; din = '0;
        lat = 0; rd = '0; lk1 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge i_clk);
            if (k == 1) lk1 = o_locked;
            if (drdy) begin
                lat = k; rd = dout;
                break;
            end
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge i_clk);
    endtask

    task automatic pattern(input string nm, input int p0, input int p1, input int lk, input int n);
        int bad0, bad1, d;
        logic e0, e1;
        bad0 = 0; bad1 = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge i_clk);
            d  = cyc - lk;
            e0 = (d > 0) && (d % p0 == 0);
            e1 = (p1 > 0) && (d > 0) && (d % p1 == 0);
            if (o_clk_en[0] !== e0) bad0++;
            if (p1 > 0 && o_clk_en[1] !== e1) bad1++;
        end
        check({nm, " ch0 bad cycles"}, bad0, 0);
        if (p1 > 0) check({nm, " ch1 bad cycles"}, bad1, 0);
    endtask

    initial begin
        logic [15:0] rd;
        logic        lk1;
        int          lat, cap, bad, nrdy, first, exp_ph, exp_first;

        vecs[0]  = '{11'h001, 1'b0, 16'h0000, 16'h0000};
        vecs[1]  = '{11'h008, 1'b0, 16'h0000, 16'h0001};
        vecs[2]  = '{11'h00A, 1'b0, 16'h0000, 16'h0001};
        vecs[3]  = '{11'h000, 1'b0, 16'h0000, 16'h0000};
        vecs[4]  = '{11'h009, 1'b0, 16'h0000, 16'h0000};
        vecs[5]  = '{11'h7FF, 1'b1, 16'hFFFF, 16'h0000};
        vecs[6]  = '{11'h7FF, 1'b0, 16'h0000, 16'h0000};
        vecs[7]  = '{11'h008, 1'b0, 16'h0000, 16'h0001};
        vecs[8]  = '{11'h00C, 1'b1, 16'h0007, 16'h0000};
        vecs[9]  = '{11'h00C, 1'b0, 16'h0000, 16'h0000};
        vecs[10] = '{11'h008, 1'b1, 16'h0004, 16'h0000};
        vecs[11] = '{11'h008, 1'b0, 16'h0000, 16'h0004};
        vecs[12] = '{11'h00A, 1'b1, 16'h0003, 16'h0000};
        vecs[13] = '{11'h00A, 1'b0, 16'h0000, 16'h0003};

        repeat (3) @(negedge i_clk);
        check("reset dout", int'(dout), 0);
        check("reset drdy", int'(drdy), 0);
        check("reset clk_en", int'(o_clk_en), 0);
        check("reset locked", int'(o_locked), 0);
        i_reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            xfer(vecs[i].addr, vecs[i].we, vecs[i].data, rd, lat, cap, lk1);
            check($sformatf("vec%0d latency", i), lat, LATENCY);
            check($sformatf("vec%0d dout", i), int'(rd), int'(vecs[i].exp));
        end

        // enable, lock timing, both channel periods
        xfer(11'h000, 1'b1, 16'h0001, rd, lat, cap, lk1);
        wait_until(cap + LOCK_CYCLES - 1);
        check("lock early", int'(o_locked), 0);
        @(negedge i_clk);
        check("lock on time", int'(o_locked), 1);
        pattern("div4/div3", 4, 3, cap + LOCK_CYCLES, 25);

        // second den while BUSY must be ignored
        @(negedge i_clk);
        daddr = 11'h008; dwe = 1'b0; den = 1'b1;
        @(posedge i_clk);
        #1;
        daddr = 11'h00A; dwe = 1'b1; din = 16'h0009;
        @(posedge i_clk);
        #1;
        den = 1'b0; dwe = 1'b0; din = '0;
        nrdy = 0; rd = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge i_clk);
            if (drdy) begin nrdy++; rd = dout; end
        end
        check("busy den drdy count", nrdy, 1);
        check("busy den read data", int'(rd), 4);
        check("busy den lock kept", int'(o_locked), 1);
        xfer(11'h00A, 1'b0, 16'h0000, rd, lat, cap, lk1);
        check("busy den DIV_1 kept", int'(rd), 3);

        // rewrite DIV_0 while running
        xfer(11'h008, 1'b1, 16'h0005, rd, lat, cap, lk1);
        check("div rewrite lock drop", int'(lk1), 0);
        wait_until(cap + LOCK_CYCLES - 1);
        check("relock early", int'(o_locked), 0);
        @(negedge i_clk);
        check("relock on time", int'(o_locked), 1);
        pattern("div5", 5, 0, cap + LOCK_CYCLES, 22);

        // soft reset: lock drops, ENABLE kept, SOFT_RST reads 0
        xfer(11'h000, 1'b1, 16'h0003, rd, lat, cap, lk1);
        check("soft rst lock drop", int'(lk1), 0);
        xfer(11'h000, 1'b0, 16'h0000, rd, lat, first, lk1);
        check("ctrl after soft rst", int'(rd), 1);
        wait_until(cap + LOCK_CYCLES);
        check("soft rst relock", int'(o_locked), 1);

        // disable: nothing runs
        xfer(11'h000, 1'b1, 16'h0000, rd, lat, cap, lk1);
        check("disable lock drop", int'(lk1), 0);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            if (o_clk_en != '0 || o_locked) bad++;
        end
        check("disabled idle cycles", bad, 0);

        // phase offset (or its absence)
`ifdef DRP_CLK_DIV_PHASE_EN
        exp_ph = 3; exp_first = 5;
`else
        exp_ph = 0; exp_first = 8;
`endif
        xfer(11'h008, 1'b1, 16'h0008, rd, lat, cap, lk1);
        xfer(11'h009, 1'b1, 16'h0003, rd, lat, cap, lk1);
        check("phase write drdy", lat, LATENCY);
        xfer(11'h009, 1'b0, 16'h0000, rd, lat, cap, lk1);
        check("phase readback", int'(rd), exp_ph);
        xfer(11'h000, 1'b1, 16'h0001, rd, lat, cap, lk1);
        wait_until(cap + LOCK_CYCLES);
        check("phase lock", int'(o_locked), 1);
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge i_clk);
            if (o_clk_en[0]) begin first = k; break; end
        end
        check("first pulse after lock", first, exp_first);
        xfer(11'h001, 1'b0, 16'h0000, rd, lat, cap, lk1);
        check("status locked", int'(rd), 1);

        // reset while a request is in flight
        @(negedge i_clk);
        daddr = 11'h008; dwe = 1'b0; den = 1'b1;
        @(posedge i_clk);
        #1;
        den = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b1;
        nrdy = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            if (drdy) nrdy++;
        end
        i_reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            if (drdy) nrdy++;
        end
        check("reset drops drdy", nrdy, 0);
        check("post reset locked", int'(o_locked), 0);
        xfer(11'h008, 1'b0, 16'h0000, rd, lat, cap, lk1);
        check("post reset DIV_0", int'(rd), 1);
        check("post reset latency", lat, LATENCY);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/drp_clk_div.md
# drp_clk_div

DRP responder implementing a soft clock-enable generator: it accepts Xilinx-style Dynamic Reconfiguration Port (DRP) read/write strobes from a DRP initiator such as the system's register-bus→DRP bridge, backs them with a small register file, and drives per-channel divided clock-enable strobes plus a lock indicator. It is the target side of the same DRP protocol the MMCM exposes. It is used where the fabric needs reconfigurable slow strobes without consuming an MMCM.

## Interface
Parameters:
- NUM_DIV, 2, number of divider channels (1..8)
- LATENCY, 2, cycles from accepted den to drdy (≥1)
- LOCK_CYCLES, 16, cycles from enable/reconfig to o_locked

Ports:
- i_clk  input  1  sole clock; DRP dclk is i_clk
- i_reset  input  1  asynchronous, active-high reset
- daddr  input  11  DRP address
- den  input  1  DRP request strobe, one cycle
- dwe  input  1  write qualifier, valid with den
- din  input  16  write data, valid with den
- dout  output  16  read data, valid only with drdy, else 0
- drdy  output  1  one-cycle response strobe for every accepted request
- o_clk_en  output  NUM_DIV  per-channel one-cycle enable pulses
- o_locked  output  1  dividers running with stable configuration

## Operation
- Register map (16-bit): 0x000 CTRL (bit0 ENABLE, bit1 SOFT_RST self-clearing, reads 0); 0x001 STATUS (bit0 locked, RO); 0x008+2·i DIV_i; 0x009+2·i PHASE_i (see Configuration). Unmapped: reads 0, writes ignored, drdy still returned.
- FSM: IDLE → (den) BUSY → after LATENCY−1 further cycles RESP → IDLE. LATENCY=1: IDLE → RESP directly.
- Request captured in IDLE only; den in BUSY/RESP ignored, no drdy generated.
- Writes commit on the capture cycle; read data snapshotted on capture cycle and held to RESP.
- DIV_i 0 or 1 = divide-by-1 (o_clk_en[i] high every cycle while running). Otherwise counter runs 0..DIV_i−1; pulse when count == DIV_i−1, then wraps to 0.
- Channels run only when ENABLE=1 and o_locked=1; otherwise counters held at restart value, o_clk_en=0.
- Lock counter: cleared by ENABLE 0→1, any DIV/PHASE write, SOFT_RST; counts to LOCK_CYCLES, then o_locked=1. ENABLE=0 forces o_locked=0.
- DIV_i write restarts channel i counter; other channels unaffected in count but gated by o_locked drop.
- SOFT_RST: clears lock and all counters; registers keep values.

## Timing
- Reset values: dout=0, drdy=0, o_clk_en=0, o_locked=0, CTRL=0, DIV_i=1, PHASE_i=0, FSM IDLE.
- den at cycle N → drdy at N+LATENCY exactly; next request accepted at N+LATENCY+1 earliest.
- STATUS read reflects o_locked at capture cycle.
- Write ENABLE=1 at N → o_locked at N+1+LOCK_CYCLES; first o_clk_en pulse DIV cycles after lock (minus PHASE).
- Reset mid-transaction: pending drdy dropped, no response.
- Write-to-CTRL clearing ENABLE concurrent with pulse cycle: pulse of that cycle suppressed from next cycle on; commit is registered.

## Configuration
- DRP_CLK_DIV_PHASE_EN defined: PHASE_i registers exist (R/W, value masked mod DIV_i); counter restarts load PHASE_i, shifting pulses earlier by PHASE_i cycles.
- Undefined: PHASE_i reads 0, writes ignored (still drdy); counters restart at 0.

## Structure
- Shared package drp_pkg: DRP address/data widths, register offsets (CTRL, STATUS, DIV base, PHASE base), CTRL bit indices, FSM state encoding.
- Sub-module clk_div_chan: one counter channel (div, phase, restart, run → pulse), instantiated NUM_DIV times.

## Test plan
- Reset then read STATUS → drdy exactly LATENCY cycles after den, dout=0x0000; read DIV_0 → 0x0001.
- Write DIV_0=4, DIV_1=3, CTRL=1 → o_locked after LOCK_CYCLES+1; o_clk_en[0] every 4th cycle, [1] every 3rd.
- Issue den while BUSY → ignored, only one drdy; register unchanged by second request.
- Rewrite DIV_0=5 while running → o_locked drops next cycle, relocks after LOCK_CYCLES, period 5.
- Read 0x7FF and write 0x7FF → drdy returned, dout=0, no state change.
- With DRP_CLK_DIV_PHASE_EN: DIV_0=8, PHASE_0=3 → first pulse 5 cycles after lock; without: PHASE_0 reads 0, first pulse 8 cycles after lock.
